// File: rtl/timebase_pkg.sv
// timebase_pkg -- shared defaults, FSM state type and cfg address width helper.
// Rev 1.0
`default_nettype none

package timebase_pkg;

   localparam int DEF_NCH    = 4;
   localparam int DEF_CW     = 32;
   localparam int DEF_PERIOD = 25000;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int cfg_aw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/timebase_channel.sv
// timebase_channel -- one terminal-count channel with shadowed period update.
// Rev 1.0; tog flop present only when TIMEBASE_TOGGLE_EN is defined.
`default_nettype none

module timebase_channel
   import timebase_pkg::*;
#(
   parameter int CW         = DEF_CW,
   parameter int RST_PERIOD = DEF_PERIOD
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_active,
   input  logic          i_leave,
   input  logic          i_en,
   input  logic          i_pre_tick,
   input  logic          i_wr,
   input  logic [CW-1:0] i_data,
   output logic          o_tick,
   output logic          o_tog,
   output logic          o_pending
);

   logic [CW-1:0] r_ctr;
   logic [CW-1:0] r_period;
   logic [CW-1:0] r_shadow;
   logic          r_pending;
   logic          r_tick;

   logic w_imm;
   logic w_wrap;
   logic w_direct;
   logic w_shadow_wr;
   logic w_apply;

   // Writes and pending shadows take effect at once whenever the channel is not counting on.
   assign w_imm       = !i_active || i_leave || !i_en;
   assign w_wrap      = i_active && i_en && i_pre_tick && (r_ctr >= r_period);
   assign w_direct    = i_wr && w_imm;
   assign w_shadow_wr = i_wr && !w_imm;
   assign w_apply     = r_pending && (w_imm || w_wrap);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctr <= '0;
      end else if (!i_active || !i_en || w_direct) begin
         r_ctr <= '0;
      end else if (i_pre_tick) begin
         r_ctr <= w_wrap ? '0 : r_ctr + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period  <= CW'(RST_PERIOD);
         r_shadow  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (w_direct) begin
            r_period <= i_data;
         end else if (w_apply) begin
            r_period <= r_shadow;
         end
         if (w_apply) begin
            r_pending <= 1'b0;
         end
         if (w_shadow_wr) begin
            r_shadow  <= i_data;
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
      end
   end

`ifdef TIMEBASE_TOGGLE_EN
   logic r_tog;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tog <= 1'b0;
      end else if (w_wrap) begin
         r_tog <= !r_tog;
      end
   end

   assign o_tog = r_tog;
`else
   assign o_tog = 1'b0;
`endif

   assign o_tick    = r_tick;
   assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/timebase_ctrl.sv
// timebase_ctrl -- shared prescaler, RUN/IDLE FSM and cfg decode for NCH timebase channels.
// Rev 1.0; optional tog outputs enabled by macro TIMEBASE_TOGGLE_EN.
`default_nettype none

module timebase_ctrl
   import timebase_pkg::*;
#(
   parameter int NCH            = DEF_NCH,
   parameter int CW             = DEF_CW,
   parameter int PRESCALE       = 2,
   parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic [NCH-1:0]         ch_en,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [cfg_aw(NCH)-1:0] cfg_addr,
   input  logic [CW-1:0]          cfg_data,
   output logic [NCH-1:0]         tick,
   output logic [NCH-1:0]         tog,
   output logic                   busy
);

   localparam int              c_aw       = cfg_aw(NCH);
   localparam int              c_pw       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pw-1:0] c_pre_last = c_pw'(PRESCALE - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_leave;
   logic            w_active;
   logic [c_pw-1:0] r_pres;
   logic            w_pre_tick;
   logic            w_addr_ok;
   logic            w_accept;
   logic [NCH-1:0]  w_wr;
   logic [NCH-1:0]  w_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_leave     = 1'b0;
      case (r_state)
         IDLE: begin
            if (run) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (!run) begin
               w_state_nxt = IDLE;
               w_leave     = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_active   = (r_state == RUN);
   assign w_pre_tick = w_active && (r_pres == c_pre_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pres <= '0;
      end else if (!w_active || w_pre_tick) begin
         r_pres <= '0;
      end else begin
         r_pres <= r_pres + c_pw'(1);
      end
   end

   // Out-of-range addresses are always ready and decode to no channel.
   assign w_addr_ok = (32'(cfg_addr) < 32'(NCH));

   always_comb begin
      cfg_ready = 1'b1;
      if (w_addr_ok) begin
         cfg_ready = !w_pending[cfg_addr];
      end
   end

   assign w_accept = cfg_valid && cfg_ready && w_addr_ok;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign w_wr[i] = w_accept && (cfg_addr == c_aw'(i));

      timebase_channel #(
         .CW         (CW),
         .RST_PERIOD (DEFAULT_PERIOD)
      ) u_channel (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_active   (w_active),
         .i_leave    (w_leave),
         .i_en       (ch_en[i]),
         .i_pre_tick (w_pre_tick),
         .i_wr       (w_wr[i]),
         .i_data     (cfg_data),
         .o_tick     (tick[i]),
         .o_tog      (tog[i]),
         .o_pending  (w_pending[i])
      );
   end

   assign busy = |w_pending;

endmodule

`default_nettype wire

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of timebase channels.
REQ-002 Parameter CW, default 32: channel counter and period width.
REQ-003 Parameter PRESCALE, default 2: shared prescaler divide ratio, legal range 1 to 256.
REQ-004 Parameter DEFAULT_PERIOD, default 25000: reset terminal count of every channel.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  global enable.
- ch_en  in  NCH  per-channel enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_addr  in  clog2(NCH)  target channel.
- cfg_data  in  CW  new terminal count.
- tick  out  NCH  one-cycle strobe per channel wrap.
- tog  out  NCH  divided level, toggles on wrap.
- busy  out  1  OR of all pending shadows.

Function
REQ-006 FSM states: IDLE and RUN. IDLE->RUN when run=1; RUN->IDLE when run=0; each transition takes effect on the next clk edge.
REQ-007 In IDLE, hold the prescaler and all channel counters at 0, hold tick at 0, and keep tog unchanged.
REQ-008 In RUN, the prescaler counts 0..PRESCALE-1 and wraps; pre_tick is high in the cycle the count equals PRESCALE-1.
REQ-009 On pre_tick with ch_en[i]=1: if ctr[i] >= period[i], ctr[i] becomes 0, tick[i] goes high for the next cycle only, and tog[i] inverts; otherwise ctr[i] increments.
REQ-010 Channel period in pre_ticks is period[i]+1; period 0 gives one tick per pre_tick. Unsigned compare, no overflow possible.
REQ-011 ch_en[i]=0 clears ctr[i] to 0 and suppresses tick[i]; tog[i] holds its value.
REQ-012 A cfg handshake completes when cfg_valid and cfg_ready are both high; cfg_ready = !pending[cfg_addr] (combinational).
REQ-013 Accepted write in IDLE, or to a channel with ch_en=0: period is updated on the next edge, ctr is cleared, and no shadow is set.
REQ-014 Accepted write to an enabled channel in RUN: cfg_data goes to shadow[i] and pending[i] is set. At that channel's next wrap, period takes the shadow value and pending clears.
REQ-015 Write accepted in the same cycle as a wrap of that channel: the current wrap uses the old period; the shadow applies at the following wrap.
REQ-016 RUN->IDLE or ch_en[i] falling with pending[i]=1: shadow[i] is applied immediately and pending[i] clears.
REQ-017 A cfg_addr value >= NCH is accepted and ignored.

Reset
REQ-018 rst_n low asynchronously forces the following, and all outputs are valid from the first edge after rst_n rises:
- state IDLE;
- prescaler, ctr, tick, tog, pending and busy all 0;
- every period set to DEFAULT_PERIOD;
- cfg_ready 1.
REQ-019 Reset during a pending update discards the shadow.

Configuration
REQ-020 Macro TIMEBASE_TOGGLE_EN: when defined, the tog outputs are generated per REQ-009. When undefined, tog is tied to 0 and its flops are removed; tick behaviour is unchanged.

Structure
REQ-021 Package timebase_pkg holds:
- NCH, CW and DEFAULT_PERIOD defaults;
- the state typedef (IDLE, RUN);
- the cfg address width function.
REQ-022 Sub-module timebase_channel is instantiated NCH times. It holds ctr, period, shadow, pending, tick and tog. The prescaler, FSM and cfg decode stay in the top level.

Verification
REQ-023 Reset release with defaults and run=1, ch_en=0001: the first tick[0] comes 50002 cycles after the RUN transition; tog[0] toggles with period 50002.
REQ-024 PRESCALE=2, write period 3 to channel 1 while in IDLE, then run=1: tick[1] pulses every 8 cycles, and busy stays 0.
REQ-025 Channel 2 running with period 3; write 7 mid-period: cfg_ready[addr2] drops, busy=1, and the next interval is still 8 cycles. Intervals after that are 16 cycles, and busy returns to 0 at that wrap.
REQ-026 Write coinciding with a channel 0 wrap: that wrap uses the old period; the new period takes effect one wrap later. A second write to channel 0 while pending=1 is stalled until the wrap.
REQ-027 Drop run with pending[3]=1: counters go to 0, period[3] takes the new value, busy=0, and tog holds its value.
REQ-028 Assert rst_n low mid-count: all outputs go to their reset values without waiting for a clk edge, and period reverts to 25000.
